// File: rtl/data_mem_arbiter.sv
// Core-priority arbiter for the single-port data RAM; grants and RAM mux are combinational, read data returns 1 cycle later.
// Backpressure via *_ready_o; a starved aux port gets one forced transfer that holds the core off for that cycle.
module data_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              core_valid_i,
    input  logic              core_we_i,
    input  logic [1:0]        core_size_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [DATA_W-1:0] core_wdata_i,
    output logic              core_ready_o,
    output logic              core_rvalid_o,
    output logic [DATA_W-1:0] core_rdata_o,
    input  logic              aux_valid_i,
    input  logic              aux_we_i,
    input  logic [1:0]        aux_size_i,
    input  logic [ADDR_W-1:0] aux_addr_i,
    input  logic [DATA_W-1:0] aux_wdata_i,
    output logic              aux_ready_o,
    output logic              aux_rvalid_o,
    output logic [DATA_W-1:0] aux_rdata_o,
    output logic              mem_we_o,
    output logic [1:0]        mem_size_o,
    output logic [ADDR_W-1:0] mem_a_o,
    output logic [DATA_W-1:0] mem_wd_o,
    input  logic [DATA_W-1:0] mem_rd_i,
    output logic              force_aux_o
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef struct packed {
        logic              we;
        logic [1:0]        size;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gnt_core, gnt_aux;
    req_t             core_req, aux_req, mem_req;

    assign core_req = {core_we_i, core_size_i, core_addr_i, core_wdata_i};
    assign aux_req  = {aux_we_i, aux_size_i, aux_addr_i, aux_wdata_i};

    assign gnt_core = core_valid_i & ~((state_q == FORCE) & aux_valid_i);
    assign gnt_aux  = aux_valid_i & (~core_valid_i | (state_q == FORCE));

    assign core_ready_o = gnt_core;
    assign aux_ready_o  = gnt_aux;
    assign force_aux_o  = (state_q == FORCE);

    // Idle bus parks at word size with everything else zero, so no write leaks without a grant.
    always_comb begin
        mem_req      = '0;
        mem_req.size = 2'b10;
        if (gnt_core) begin
            mem_req = core_req;
        end else if (gnt_aux) begin
            mem_req = aux_req;
        end
    end

    assign mem_we_o   = mem_req.we;
    assign mem_size_o = mem_req.size;
    assign mem_a_o    = mem_req.addr;
    assign mem_wd_o   = mem_req.wdata;

    always_comb begin
        cnt_d = '0;
        if (aux_valid_i && !gnt_aux) begin
            cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            NORMAL:  if (cnt_d == LIMIT) state_d = FORCE;
            FORCE:   if (gnt_aux || !aux_valid_i) state_d = NORMAL;
            default: state_d = NORMAL;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= NORMAL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Read data is captured only for the port that owned the RAM this cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            core_rvalid_o <= 1'b0;
            core_rdata_o  <= '0;
            aux_rvalid_o  <= 1'b0;
            aux_rdata_o   <= '0;
        end else begin
            core_rvalid_o <= gnt_core & ~core_we_i;
            aux_rvalid_o  <= gnt_aux & ~aux_we_i;
            if (gnt_core && !core_we_i) core_rdata_o <= mem_rd_i;
            if (gnt_aux && !aux_we_i)   aux_rdata_o  <= mem_rd_i;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: vector table, corner-case sequences, and random traffic against a starvation/grant model.
module tb_data_mem_arbiter;

    localparam int LIM = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        core_v, core_we, aux_v, aux_we;
    logic [1:0]  core_sz, aux_sz;
    logic [31:0] core_a, core_wd, aux_a, aux_wd;
    logic        core_rdy, core_rv, aux_rdy, aux_rv;
    logic [31:0] core_rd, aux_rd;
    logic        mem_we, force_aux;
    logic [1:0]  mem_sz;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic        rd_force = 1'b0;
    logic [31:0] rd_val = 32'h0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign mem_rd = rd_force ? rd_val : rd_of(mem_a);

    data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
        .clk_i(clk), .rst_i(rst),
        .core_valid_i(core_v), .core_we_i(core_we), .core_size_i(core_sz),
        .core_addr_i(core_a), .core_wdata_i(core_wd), .core_ready_o(core_rdy),
        .core_rvalid_o(core_rv), .core_rdata_o(core_rd),
        .aux_valid_i(aux_v), .aux_we_i(aux_we), .aux_size_i(aux_sz),
        .aux_addr_i(aux_a), .aux_wdata_i(aux_wd), .aux_ready_o(aux_rdy),
        .aux_rvalid_o(aux_rv), .aux_rdata_o(aux_rd),
        .mem_we_o(mem_we), .mem_size_o(mem_sz), .mem_a_o(mem_a), .mem_wd_o(mem_wd),
        .mem_rd_i(mem_rd), .force_aux_o(force_aux)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic cv, input logic cwe, input logic [1:0] cs,
                          input logic [31:0] ca, input logic [31:0] cwd,
                          input logic av, input logic awe, input logic [1:0] as,
                          input logic [31:0] aa, input logic [31:0] awd);
        core_v = cv; core_we = cwe; core_sz = cs; core_a = ca; core_wd = cwd;
        aux_v = av;  aux_we = awe;  aux_sz = as;  aux_a = aa;  aux_wd = awd;
    endtask

    task automatic idle();
        set_in(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    typedef struct {
        logic cv, cwe; logic [1:0] cs; logic [31:0] ca, cwd;
        logic av, awe; logic [1:0] as; logic [31:0] aa, awd;
        logic erc, era, ewe; logic [1:0] esz; logic [31:0] ea, ewd;
        logic ecrv, earv;
    } vec_t;

    vec_t vecs[7];

    // random-test model state
    int          m_cnt;
    logic        m_force, e_gc, e_ga, e_crv, e_arv, hold_c, hold_a;
    logic [31:0] e_crd, e_ard;

    initial begin
        vecs[0] = '{1'b0,1'b0,2'b00,32'h0,32'h0,     1'b0,1'b0,2'b00,32'h0,32'h0,   1'b0,1'b0,1'b0,2'b10,32'h0,32'h0,     1'b0,1'b0};
        vecs[1] = '{1'b1,1'b0,2'b10,32'h100,32'h11,  1'b0,1'b0,2'b00,32'h0,32'h0,   1'b1,1'b0,1'b0,2'b10,32'h100,32'h11,  1'b1,1'b0};
        vecs[2] = '{1'b1,1'b1,2'b01,32'h104,32'hCAFE,1'b0,1'b0,2'b00,32'h0,32'h0,   1'b1,1'b0,1'b1,2'b01,32'h104,32'hCAFE,1'b0,1'b0};
        vecs[3] = '{1'b0,1'b0,2'b00,32'h0,32'h0,     1'b1,1'b1,2'b00,32'h20,32'h55, 1'b0,1'b1,1'b1,2'b00,32'h20,32'h55,   1'b0,1'b0};
        vecs[4] = '{1'b0,1'b0,2'b00,32'h0,32'h0,     1'b1,1'b0,2'b10,32'h40,32'h0,  1'b0,1'b1,1'b0,2'b10,32'h40,32'h0,    1'b0,1'b1};
        vecs[5] = '{1'b1,1'b0,2'b00,32'h8,32'h77,    1'b1,1'b1,2'b01,32'hC,32'h99,  1'b1,1'b0,1'b0,2'b00,32'h8,32'h77,    1'b1,1'b0};
        vecs[6] = '{1'b1,1'b1,2'b10,32'h10,32'hAB,   1'b1,1'b0,2'b10,32'h30,32'h0,  1'b1,1'b0,1'b1,2'b10,32'h10,32'hAB,   1'b0,1'b0};

        idle();
        // Asynchronous reset between edges, from an active state
        #2;
        do_reset();
        chk1("rst_core_rvalid", core_rv, 1'b0);
        chk1("rst_aux_rvalid", aux_rv, 1'b0);
        chk32("rst_core_rdata", core_rd, 32'h0);
        chk1("rst_force", force_aux, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk32("rst_mem_size", {30'b0, mem_sz}, 32'h2);

        set_in(1'b1, 1'b0, 2'b10, 32'h80, 32'h0, 1'b1, 1'b0, 2'b10, 32'h90, 32'h0);
        for (int i = 0; i < LIM; i++) step();
        #1;
        chk1("pre_async_force", force_aux, 1'b1);
        chk1("pre_async_rvalid", core_rv, 1'b1);
        rst = 1'b1;
        #1;
        chk1("async_force_clr", force_aux, 1'b0);
        chk1("async_rvalid_clr", core_rv, 1'b0);
        chk1("async_core_rdy", core_rdy, 1'b1);
        chk1("async_aux_rdy", aux_rdy, 1'b0);
        idle();
        #1;
        chk1("async_mem_we", mem_we, 1'b0);
        step();
        rst = 1'b0;

        // Vector table, separated by idle cycles so each starts from a cleared counter
        do_reset();
        foreach (vecs[k]) begin
            set_in(vecs[k].cv, vecs[k].cwe, vecs[k].cs, vecs[k].ca, vecs[k].cwd,
                   vecs[k].av, vecs[k].awe, vecs[k].as, vecs[k].aa, vecs[k].awd);
            #1;
            chk1($sformatf("v%0d_core_rdy", k), core_rdy, vecs[k].erc);
            chk1($sformatf("v%0d_aux_rdy", k), aux_rdy, vecs[k].era);
            chk1($sformatf("v%0d_mem_we", k), mem_we, vecs[k].ewe);
            chk32($sformatf("v%0d_mem_size", k), {30'b0, mem_sz}, {30'b0, vecs[k].esz});
            chk32($sformatf("v%0d_mem_a", k), mem_a, vecs[k].ea);
            chk32($sformatf("v%0d_mem_wd", k), mem_wd, vecs[k].ewd);
            step();
            idle();
            chk1($sformatf("v%0d_core_rv", k), core_rv, vecs[k].ecrv);
            chk1($sformatf("v%0d_aux_rv", k), aux_rv, vecs[k].earv);
            if (vecs[k].ecrv) chk32($sformatf("v%0d_core_rd", k), core_rd, rd_of(vecs[k].ca));
            if (vecs[k].earv) chk32($sformatf("v%0d_aux_rd", k), aux_rd, rd_of(vecs[k].aa));
            step();
            chk1($sformatf("v%0d_rv_pulse", k), core_rv | aux_rv, 1'b0);
        end

        // Core read with RAM returning 0xDEADBEEF
        do_reset();
        rd_force = 1'b1;
        rd_val   = 32'hDEAD_BEEF;
        set_in(1'b1, 1'b0, 2'b10, 32'h100, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        #1;
        chk1("beef_core_rdy", core_rdy, 1'b1);
        step();
        idle();
        chk1("beef_core_rv", core_rv, 1'b1);
        chk32("beef_core_rd", core_rd, 32'hDEAD_BEEF);
        chk1("beef_aux_rv", aux_rv, 1'b0);
        chk32("beef_aux_rd", aux_rd, 32'h0);
        step();
        chk1("beef_rv_drop", core_rv, 1'b0);
        chk32("beef_rd_hold", core_rd, 32'hDEAD_BEEF);
        rd_force = 1'b0;

        // Continuous contention: LIM core grants, one forced aux, then core again
        do_reset();
        set_in(1'b1, 1'b0, 2'b10, 32'h200, 32'h0, 1'b1, 1'b1, 2'b10, 32'h300, 32'h5A);
        for (int i = 1; i <= LIM; i++) begin
            #1;
            chk1($sformatf("starve_c%0d_core_rdy", i), core_rdy, 1'b1);
            chk1($sformatf("starve_c%0d_force", i), force_aux, 1'b0);
            step();
            chk1($sformatf("starve_c%0d_core_rv", i), core_rv, 1'b1);
        end
        #1;
        chk1("starve_force", force_aux, 1'b1);
        chk1("starve_aux_rdy", aux_rdy, 1'b1);
        chk1("starve_core_rdy", core_rdy, 1'b0);
        chk32("starve_mem_a", mem_a, 32'h300);
        chk1("starve_mem_we", mem_we, 1'b1);
        step();
        #1;
        chk1("starve_after_core_rdy", core_rdy, 1'b1);
        chk1("starve_after_force", force_aux, 1'b0);
        chk1("starve_aux_no_rv", aux_rv, 1'b0);

        // FORCE with aux dropping: core proceeds, counter restarts from 0
        do_reset();
        set_in(1'b1, 1'b1, 2'b10, 32'h400, 32'h1, 1'b1, 1'b0, 2'b10, 32'h500, 32'h0);
        for (int i = 0; i < LIM; i++) step();
        aux_v = 1'b0;
        #1;
        chk1("drop_force_now", force_aux, 1'b1);
        chk1("drop_core_rdy", core_rdy, 1'b1);
        chk1("drop_aux_rdy", aux_rdy, 1'b0);
        step();
        aux_v = 1'b1;
        for (int i = 1; i <= LIM; i++) begin
            #1;
            chk1($sformatf("drop_re%0d_force", i), force_aux, 1'b0);
            step();
        end
        #1;
        chk1("drop_reforce", force_aux, 1'b1);

        // Reset straddling the edge after a granted core read drops the response
        do_reset();
        set_in(1'b1, 1'b0, 2'b10, 32'h100, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        #1;
        chk1("rpulse_core_rdy", core_rdy, 1'b1);
        rst = 1'b1;
        step();
        chk1("rpulse_rv_in_rst", core_rv, 1'b0);
        idle();
        rst = 1'b0;
        step();
        chk1("rpulse_rv_after1", core_rv, 1'b0);
        step();
        chk1("rpulse_rv_after2", core_rv, 1'b0);
        chk32("rpulse_rd", core_rd, 32'h0);

        // Random traffic against the model
        do_reset();
        m_cnt = 0; e_crd = 32'h0; e_ard = 32'h0;
        hold_c = 1'b0; hold_a = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (!hold_c) begin
                core_we = 1'($urandom_range(0, 1)); core_sz = 2'($urandom_range(0, 2));
                core_a = $urandom; core_wd = $urandom;
            end
            if (!hold_a) begin
                aux_we = 1'($urandom_range(0, 1)); aux_sz = 2'($urandom_range(0, 2));
                aux_a = $urandom; aux_wd = $urandom;
            end
            core_v = hold_c | ($urandom_range(0, 9) < 8);
            aux_v  = $urandom_range(0, 9) < 9;

            m_force = (m_cnt == LIM);
            e_ga = aux_v && (!core_v || m_force);
            e_gc = core_v && !e_ga;
            #1;
            chk1("rnd_core_rdy", core_rdy, e_gc);
            chk1("rnd_aux_rdy", aux_rdy, e_ga);
            chk1("rnd_force", force_aux, m_force);
            chk1("rnd_mem_we", mem_we, e_gc ? core_we : (e_ga ? aux_we : 1'b0));
            chk32("rnd_mem_a", mem_a, e_gc ? core_a : (e_ga ? aux_a : 32'h0));
            chk32("rnd_mem_wd", mem_wd, e_gc ? core_wd : (e_ga ? aux_wd : 32'h0));
            chk32("rnd_mem_size", {30'b0, mem_sz}, {30'b0, e_gc ? core_sz : (e_ga ? aux_sz : 2'b10)});

            e_crv = e_gc && !core_we;
            e_arv = e_ga && !aux_we;
            if (e_crv) e_crd = rd_of(core_a);
            if (e_arv) e_ard = rd_of(aux_a);
            m_cnt = (aux_v && !e_ga) ? ((m_cnt + 1 > LIM) ? LIM : m_cnt + 1) : 0;
            hold_c = core_v && !e_gc;
            hold_a = aux_v && !e_ga;
            step();
            chk1("rnd_core_rv", core_rv, e_crv);
            chk1("rnd_aux_rv", aux_rv, e_arv);
            chk32("rnd_core_rd", core_rd, e_crd);
            chk32("rnd_aux_rd", aux_rd, e_ard);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
